// File: rtl/isa_pkg.sv
// Shared ISA constants for the instruction loader and the processor decode path.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: opcode encodings, instruction field positions, loader error codes.
package isa_pkg;

  localparam int INSTR_W    = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_NORI  = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_LW    = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_SW    = 4'd9;

  // Loader abort reasons reported on err_code.
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OPCODE   = 2'd1;
  localparam logic [1:0] ERR_LENGTH   = 2'd2;
  localparam logic [1:0] ERR_CHECKSUM = 2'd3;

endpackage

// File: rtl/opcode_legal.sv
// Flags whether an opcode belongs to the implemented ISA (opcode <= MAX_OPCODE).
// Latency: purely combinational.
// Backpressure: none.
// Ports: opcode (in, OPCODE_W) field under test; legal (out, 1) high for a legal opcode.
module opcode_legal
  import isa_pkg::*;
#(
  parameter int MAX_OPCODE = 9
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic                legal
);

  assign legal = (int'(opcode) <= MAX_OPCODE);

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed byte stream of 16-bit instructions into imem, holding the CPU until done.
// Latency: one word written per >= 3 cycles (hi byte, lo byte, write cycle); all outputs registered.
// Backpressure: in_ready is high only in byte-accepting states; WRITE and terminal states stall the stream.
// Ports: clk/rst (async active-high); start pulse; in_data/in_valid/in_ready byte stream;
//        imem_we/imem_addr/imem_wdata write port; cpu_hold, done, error, err_code, words_loaded status.
// Option: define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte over instruction bytes.
module prog_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int MAX_OPCODE = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [ADDR_W:0]    words_loaded
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_INS_HI, S_INS_LO, S_WRITE, S_DONE, S_ERROR
`ifdef PROG_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  // State entered once the last instruction has been taken.
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHK;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t      state, state_nxt;
  logic [15:0] len;
  logic [7:0]  ins_hi;
  logic [1:0]  err_nxt;
  logic        accept_nxt;
  logic        xfer;
  logic        op_ok;
  logic        start_ok;
  logic [16:0] len_rx;
  logic [16:0] wl_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign xfer     = in_valid & in_ready;
  assign start_ok = start & (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign len_rx   = {1'b0, len[15:8], in_data};
  assign wl_inc   = 17'(words_loaded) + 17'd1;

  // High byte carries the opcode in its upper nibble.
  opcode_legal #(.MAX_OPCODE(MAX_OPCODE)) u_opcode_legal (
    .opcode (in_data[7:4]),
    .legal  (op_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    err_nxt    = ERR_NONE;
    accept_nxt = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_LEN_HI;
      S_LEN_HI: if (xfer) state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (len_rx == 17'd0) begin
            state_nxt = S_TAIL;
          end else if (len_rx > 17'(DEPTH)) begin
            state_nxt = S_ERROR;
            err_nxt   = ERR_LENGTH;
          end else begin
            state_nxt = S_INS_HI;
          end
        end
      end
      S_INS_HI: begin
        if (xfer) begin
          if (!op_ok) begin
            state_nxt = S_ERROR;
            err_nxt   = ERR_OPCODE;
          end else begin
            state_nxt = S_INS_LO;
          end
        end
      end
      S_INS_LO: if (xfer) state_nxt = S_WRITE;
      S_WRITE:  state_nxt = (wl_inc < {1'b0, len}) ? S_INS_HI : S_TAIL;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          if (in_data == csum) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_ERROR;
            err_nxt   = ERR_CHECKSUM;
          end
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_LEN_HI, S_LEN_LO, S_INS_HI, S_INS_LO: accept_nxt = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: accept_nxt = 1'b1;
`endif
      default: accept_nxt = 1'b0;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
      words_loaded <= '0;
      len          <= '0;
      ins_hi       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      in_ready <= accept_nxt;
      imem_we  <= (state_nxt == S_WRITE);
      done     <= (state_nxt == S_DONE);
      error    <= (state_nxt == S_ERROR);
      cpu_hold <= (state_nxt != S_DONE);

      if (start_ok) begin
        err_code     <= ERR_NONE;
        words_loaded <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum         <= '0;
`endif
      end
      if (err_nxt != ERR_NONE) err_code <= err_nxt;

      if (xfer && state == S_LEN_HI) len[15:8] <= in_data;
      if (xfer && state == S_LEN_LO) len[7:0]  <= in_data;
      if (xfer && state == S_INS_HI) ins_hi    <= in_data;
      // Address and data are captured on the low byte so they are stable during the WRITE cycle.
      if (xfer && state == S_INS_LO) begin
        imem_addr  <= words_loaded[ADDR_W-1:0];
        imem_wdata <= {ins_hi, in_data};
      end
      if (state == S_WRITE) words_loaded <= words_loaded + {{ADDR_W{1'b0}}, 1'b1};
`ifdef PROG_LOADER_CHECKSUM_EN
      if (xfer && (state == S_INS_HI || state == S_INS_LO)) csum <= csum ^ in_data;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a stream-level reference model and a write scoreboard.
// Latency: n/a.
// Backpressure: driver inserts optional random gaps on in_valid.
module tb_prog_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int MAX_OP = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready, imem_we, cpu_hold, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  stim_q[$];
  logic [23:0] exp_q[$];
  logic [23:0] wlog[$];
  logic [23:0] e_w;
  bit          exp_done;
  logic [1:0]  exp_code;
  int          exp_words;
  int          n_use;

  prog_loader #(.ADDR_W(ADDR_W), .MAX_OPCODE(MAX_OP)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .err_code(err_code),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the byte stream by the loader's rules and predict writes and final status.
  function automatic void build_expect();
    int         len, p;
    logic [7:0] hi, lo, x;
    exp_q.delete();
    x = 8'h00; exp_done = 1'b0; exp_code = 2'd0; exp_words = 0;
    len = int'({stim_q[0], stim_q[1]});
    p = 2;
    if (len > DEPTH) begin exp_code = 2'd2; n_use = 2; return; end
    for (int w = 0; w < len; w++) begin
      hi = stim_q[p]; p++;
      if (int'(hi[7:4]) > MAX_OP) begin exp_code = 2'd1; n_use = p; return; end
      lo = stim_q[p]; p++;
      x = x ^ hi ^ lo;
      exp_q.push_back({w[7:0], hi, lo});
      exp_words++;
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    n_use = p + 1;
    if (stim_q[p] != x) begin exp_code = 2'd3; return; end
`else
    n_use = p;
`endif
    exp_done = 1'b1;
  endfunction

  // Appends the XOR of all instruction bytes when the checksum option is built in.
  function automatic void finish_stim();
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < stim_q.size(); i++) x = x ^ stim_q[i];
    stim_q.push_back(x);
`endif
  endfunction

  // Per-cycle scoreboard on the write port plus the hold/done relation.
  always @(negedge clk) begin
    if (!rst) begin
      chk("hold_vs_done", {31'd0, cpu_hold}, {31'd0, !done});
      if (imem_we) begin
        wlog.push_back({imem_addr, imem_wdata});
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_write: got %0h@%0h expected no write", imem_wdata, imem_addr);
        end else begin
          e_w = exp_q.pop_front();
          chk("imem_write", {8'd0, imem_addr, imem_wdata}, {8'd0, e_w});
        end
      end
    end
  end

  task automatic check_reset();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_words", words_loaded, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      in_data = b; in_valid = 1'b1;
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_load(input int gap_max, input bit poke);
    bit ok, seen;
    int t;
    build_expect();
    pulse_start();
    for (int i = 0; i < n_use; i++) begin
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      if (poke && i == 4) pulse_start();
      push(stim_q[i], ok);
      if (!ok) begin chk("handshake", {31'd0, ok}, 1); break; end
    end
    t = 0;
    while (!(done || error) && t < 50) begin @(negedge clk); t++; end
    chk("load_settled", {31'd0, done || error}, 1);
    repeat (2) @(negedge clk);
    chk("end_done", done, exp_done);
    chk("end_error", error, !exp_done);
    chk("end_err_code", err_code, exp_code);
    chk("end_cpu_hold", cpu_hold, !exp_done);
    chk("end_words", words_loaded, exp_words);
    chk("end_in_ready", in_ready, 0);
    chk("end_all_written", exp_q.size(), 0);
    if (stim_q.size() > n_use) begin
      in_data = stim_q[n_use]; in_valid = 1'b1; seen = 1'b0;
      repeat (4) begin @(negedge clk); if (in_ready) seen = 1'b1; end
      in_valid = 1'b0;
      chk("extra_not_taken", {31'd0, seen}, 0);
    end
  endtask

  initial begin
    bit ok;
    int t;
    repeat (2) @(negedge clk);
    check_reset();
    rst = 1'b0;

    // Nominal three-word program followed by a byte of the next load.
    stim_q = '{8'h00, 8'h03, 8'h10, 8'h05, 8'h83, 8'h04, 8'h92, 8'h01};
    finish_stim(); stim_q.push_back(8'hEE);
    wlog.delete(); run_load(0, 1'b0);
    chk("nom_nwrites", wlog.size(), 3);
    chk("nom_w0", wlog[0], 24'h001005);
    chk("nom_w1", wlog[1], 24'h018304);
    chk("nom_w2", wlog[2], 24'h029201);
    chk("nom_words", words_loaded, 3);
    chk("nom_hold", cpu_hold, 0);

    // Empty program.
    stim_q = '{8'h00, 8'h00}; finish_stim(); stim_q.push_back(8'h5A);
    wlog.delete(); run_load(0, 1'b0);
    chk("empty_nwrites", wlog.size(), 0);
    chk("empty_done", done, 1);

    // Illegal opcode in the second word; its low byte must stay in the stream.
    stim_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hA3, 8'h77};
    wlog.delete(); run_load(0, 1'b0);
    chk("ill_nwrites", wlog.size(), 1);
    chk("ill_w0", wlog[0], 24'h001234);
    chk("ill_code", err_code, 1);
    chk("ill_hold", cpu_hold, 1);

    // Length one past capacity.
    stim_q = '{8'h01, 8'h01, 8'h10};
    wlog.delete(); run_load(0, 1'b0);
    chk("ovf_nwrites", wlog.size(), 0);
    chk("ovf_code", err_code, 2);

    // Exactly full capacity.
    stim_q = '{8'h01, 8'h00};
    for (int i = 0; i < DEPTH; i++) begin
      stim_q.push_back({4'(i % 10), 4'(i)});
      stim_q.push_back(8'(i));
    end
    finish_stim();
    wlog.delete(); run_load(0, 1'b0);
    chk("full_nwrites", wlog.size(), 256);
    chk("full_last", wlog[255], 24'hFF5FFF);
    chk("full_words", words_loaded, 9'h100);
    chk("full_done", done, 1);

    // Gaps on in_valid and a stray start mid-load.
    stim_q = '{8'h00, 8'h03, 8'h10, 8'h05, 8'h83, 8'h04, 8'h92, 8'h01}; finish_stim();
    wlog.delete(); run_load(3, 1'b1);
    chk("bp_nwrites", wlog.size(), 3);
    chk("bp_w0", wlog[0], 24'h001005);
    chk("bp_w2", wlog[2], 24'h029201);

    // Reset after the first word has been written.
    stim_q = '{8'h00, 8'h03, 8'h10, 8'h05, 8'h83, 8'h04, 8'h92, 8'h01};
    build_expect();
    pulse_start();
    for (int i = 0; i < 4; i++) push(stim_q[i], ok);
    t = 0;
    while (words_loaded != 1 && t < 20) begin @(negedge clk); t++; end
    chk("midrst_word1", words_loaded, 1);
    @(negedge clk); #2 rst = 1'b1;
    #1 check_reset();
    exp_q.delete();
    @(negedge clk); rst = 1'b0;

`ifdef PROG_LOADER_CHECKSUM_EN
    // 0x10^0x05^0x83^0x04 = 0x92.
    stim_q = '{8'h00, 8'h02, 8'h10, 8'h05, 8'h83, 8'h04, 8'h92};
    wlog.delete(); run_load(0, 1'b0);
    chk("csum_ok_done", done, 1);
    stim_q = '{8'h00, 8'h02, 8'h10, 8'h05, 8'h83, 8'h04, 8'h96};
    wlog.delete(); run_load(0, 1'b0);
    chk("csum_bad_code", err_code, 3);
    chk("csum_bad_writes", wlog.size(), 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
